// File: rtl/gb_mem_pkg.sv
// gb_mem_pkg: shared CGB memory-map definitions.
//   - Region base addresses of the 16-bit system bus.
//   - src_region_e: classification of an HDMA source address.
//   - classify_src(): maps a bus address to its region.
package gb_mem_pkg;

  localparam logic [15:0] VRAM_BASE = 16'h8000;
  localparam logic [15:0] XRAM_BASE = 16'hA000;
  localparam logic [15:0] WRAM_BASE = 16'hC000;
  localparam logic [15:0] ECHO_BASE = 16'hE000;

  typedef enum logic [2:0] {
    SRC_ROM  = 3'd0,
    SRC_VRAM = 3'd1,
    SRC_XRAM = 3'd2,
    SRC_WRAM = 3'd3,
    SRC_ECHO = 3'd4
  } src_region_e;

  function automatic src_region_e classify_src(input logic [15:0] addr);
    src_region_e region;
    if (addr < VRAM_BASE) begin
      region = SRC_ROM;
    end else if (addr < XRAM_BASE) begin
      region = SRC_VRAM;
    end else if (addr < WRAM_BASE) begin
      region = SRC_XRAM;
    end else if (addr < ECHO_BASE) begin
      region = SRC_WRAM;
    end else begin
      region = SRC_ECHO;
    end
    return region;
  endfunction

endpackage

// File: rtl/hdma_src_decode.sv
// hdma_src_decode: combinational remap and classification of an HDMA source
// address.
//   addr_i    [15:0] raw source address from the HDMA controller
//   addr_o    [15:0] address to present on the system bus
//   region_o         region the raw address falls in
module hdma_src_decode
  import gb_mem_pkg::*;
(
  input  logic [15:0] addr_i,
  output logic [15:0] addr_o,
  output src_region_e region_o
);

  // Echo RAM (E000-FFFF) is served by the external RAM window, so bit 14 is
  // dropped to fold it onto A000-BFFF.
  always_comb begin
    region_o = classify_src(addr_i);
    if (region_o == SRC_ECHO) begin
      addr_o = {addr_i[15], 1'b0, addr_i[13:0]};
    end else begin
      addr_o = addr_i;
    end
  end

endmodule

// File: rtl/hdma_bus_engine.sv
// hdma_bus_engine: executes HDMA read/write pairs between the system bus and
// VRAM, owns the VRAM write port arbitration and stalls the CPU during HDMA.
//   clk, reset            clock, synchronous active-high reset
//   cpu_en                clock enable; state advances only when high
//   hdma, hdma_write      HDMA active / phase (0 = read, 1 = write)
//   hdma_src_addr         source byte address for the current pair
//   hdma_vram_addr        VRAM offset for the current pair
//   vram_bank             VBK bit 0
//   src_addr/src_re       system-bus read request; src_rdata returns the data
//   cpu_vram_*            CPU-side VRAM write request
//   vram_addr/wdata/we    VRAM write port
//   cpu_stall             CPU must hold its bus cycle
//   xfer_count            bytes written in the current/last session
//   proto_err             sticky protocol-violation flag
module hdma_bus_engine
  import gb_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic        hdma,
  input  logic [15:0] hdma_src_addr,
  input  logic [12:0] hdma_vram_addr,
  input  logic        hdma_write,
  input  logic        vram_bank,
  output logic [15:0] src_addr,
  output logic        src_re,
  input  logic [7:0]  src_rdata,
  input  logic [12:0] cpu_vram_addr,
  input  logic [7:0]  cpu_vram_wdata,
  input  logic        cpu_vram_we,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  output logic        cpu_stall,
  output logic [15:0] xfer_count,
  output logic        proto_err
);

  logic [7:0]  latch_q, latch_d;
  logic        latch_valid_q, latch_valid_d;
  logic [15:0] xfer_q, xfer_d;
  logic        err_q, err_d;
  logic        prev_hdma_q, prev_hdma_d;

  logic [15:0] remap_addr_s;
  src_region_e region_s;
  logic        read_phase_s;
  logic        write_phase_s;
  logic        src_is_vram_s;
  logic        hdma_wr_s;
  logic [15:0] xfer_base_s;

  hdma_src_decode u_src_decode (
    .addr_i   (hdma_src_addr),
    .addr_o   (remap_addr_s),
    .region_o (region_s)
  );

  assign read_phase_s  = hdma & ~hdma_write;
  assign write_phase_s = hdma & hdma_write;
  // VRAM cannot be read while it is the destination; such sources yield FF.
  assign src_is_vram_s = (region_s == SRC_VRAM);
  assign hdma_wr_s     = write_phase_s & cpu_en & latch_valid_q;
  // The count restarts on the first enabled cycle of a new session.
  assign xfer_base_s   = (hdma & ~prev_hdma_q) ? 16'h0000 : xfer_q;

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      latch_q       <= 8'hFF;
      latch_valid_q <= 1'b0;
      xfer_q        <= 16'h0000;
      err_q         <= 1'b0;
      prev_hdma_q   <= 1'b0;
    end else begin
      latch_q       <= latch_d;
      latch_valid_q <= latch_valid_d;
      xfer_q        <= xfer_d;
      err_q         <= err_d;
      prev_hdma_q   <= prev_hdma_d;
    end
  end

  // Next-state logic: latch handshake, session byte count, protocol errors.
  always_comb begin
    latch_d       = latch_q;
    latch_valid_d = latch_valid_q;
    xfer_d        = xfer_q;
    err_d         = err_q;
    prev_hdma_d   = prev_hdma_q;
    if (cpu_en) begin
      prev_hdma_d = hdma;
      xfer_d      = xfer_base_s + {15'd0, hdma_wr_s};
      if (read_phase_s) begin
        latch_d       = src_is_vram_s ? 8'hFF : src_rdata;
        latch_valid_d = 1'b1;
        // A byte still pending here would be lost.
        if (latch_valid_q) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end else if (write_phase_s) begin
        latch_valid_d = 1'b0;
        if (!latch_valid_q) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end else begin
        // HDMA ended with an unconsumed byte: discard it.
        if (latch_valid_q) begin
          latch_valid_d = 1'b0;
          err_d         = 1'b1;
        end else begin
          latch_valid_d = latch_valid_q;
        end
      end
    end else begin
      prev_hdma_d = prev_hdma_q;
    end
  end

  // Output logic: bus and VRAM port muxing; reset forces idle values at once.
  always_comb begin
    src_addr   = 16'h0000;
    src_re     = 1'b0;
    vram_addr  = 14'h0000;
    vram_wdata = 8'hFF;
    vram_we    = 1'b0;
    cpu_stall  = 1'b0;
    xfer_count = 16'h0000;
    proto_err  = 1'b0;
    if (reset) begin
      src_re = 1'b0;
    end else begin
      cpu_stall  = hdma;
      xfer_count = xfer_q;
      proto_err  = err_q;
      if (read_phase_s) begin
        src_addr   = remap_addr_s;
        src_re     = cpu_en & ~src_is_vram_s;
        vram_addr  = {vram_bank, hdma_vram_addr};
        vram_wdata = latch_q;
      end else if (write_phase_s) begin
        vram_addr  = {vram_bank, hdma_vram_addr};
        vram_wdata = latch_q;
        vram_we    = hdma_wr_s;
      end else begin
        vram_addr  = {vram_bank, cpu_vram_addr};
        vram_wdata = cpu_vram_wdata;
        vram_we    = cpu_vram_we;
      end
    end
  end

endmodule
